addsub_arbiter: RTL

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_pkg.sv | 25 ++
 rtl/ADDSUB_32.sv | 13 +
 rtl/addsub_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addsub_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  // Operation captured from the granted requester on the accept edge.
  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              sub;
    logic              id;
  } op_t;

endpackage

// File: rtl/ADDSUB_32.sv
// 32-bit adder/subtractor shared by both requesters; carry/borrow out is dropped.
// Latency: combinational.
// Backpressure: none (pure datapath).
module ADDSUB_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] s
);

  assign s = sub ? (a - b) : (a + b);

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter feeding one shared add/sub datapath, one operation in flight.
// Latency: rsp_valid rises 2 cycles after the accept cycle; issue interval >= 3 cycles.
// Backpressure: response holds in RESP until rsp_ready; requesters see ready only in IDLE.
module addsub_arbiter
  import addsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic              req0_sub,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  input  logic              req1_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_s,
  output logic              rsp_ovf,
  output logic              rsp_zero
);

  state_t            state;
  state_t            state_nxt;
  logic              ptr;
  logic              grant_id;
  logic              accept;
  op_t               op;
  logic [DATA_W-1:0] sum;
  logic              ovf;

  // Round-robin pick: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    grant_id = ptr;
    if (req0_valid && !req1_valid) begin
      grant_id = REQ_ID0;
    end else if (req1_valid && !req0_valid) begin
      grant_id = REQ_ID1;
    end
  end

  // Next-state and handshake decode; ready is only ever offered in IDLE out of reset.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          state_nxt  = EXEC;
          req0_ready = rst_n && (grant_id == REQ_ID0);
          req1_ready = rst_n && (grant_id == REQ_ID1);
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and priority pointer; pointer flips to the loser of each grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= REQ_ID0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ptr <= ~grant_id;
      end
    end
  end

  // Capture the winner's operands on the accept edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op <= '0;
    end else if (accept) begin
      op.x   <= (grant_id == REQ_ID1) ? req1_x   : req0_x;
      op.y   <= (grant_id == REQ_ID1) ? req1_y   : req0_y;
      op.sub <= (grant_id == REQ_ID1) ? req1_sub : req0_sub;
      op.id  <= grant_id;
    end
  end

  ADDSUB_32 u_addsub (
    .a   (op.x),
    .b   (op.y),
    .sub (op.sub),
    .s   (sum)
  );

  // Signed overflow: the result sign disagrees with X when the effective operands share a sign.
  assign ovf = op.sub ? ((op.x[DATA_W-1] != op.y[DATA_W-1]) && (sum[DATA_W-1] != op.x[DATA_W-1]))
                      : ((op.x[DATA_W-1] == op.y[DATA_W-1]) && (sum[DATA_W-1] != op.x[DATA_W-1]));

  // Register the result and flags at the end of EXEC; they then hold through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_s    <= '0;
      rsp_ovf  <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_id   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_s    <= sum;
      rsp_ovf  <= ovf;
      rsp_zero <= (sum == '0);
      rsp_id   <= op.id;
    end
  end

  assign rsp_valid = (state == RESP);

endmodule
